// File: rtl/wb_master_bridge_if.sv
// wb_master_bridge_if: bundles the CPU-side request/response handshake and
// the Wishbone classic master bus of wb_master_bridge.
//
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising
// clock edge where valid and ready are both high. The producer holds valid
// and its payload stable until that edge.
//
// Modports:
//   master - the bridge: consumes req_*, produces rsp_*, drives wb_* outputs
//   slave  - the environment: CPU side plus the Wishbone slave
interface wb_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   localparam int SEL_W = DATA_W / 8;

   // CPU request
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [SEL_W-1:0]  req_sel;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   // CPU response
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   // Wishbone classic
   logic              wb_cyc;
   logic              wb_stb;
   logic              wb_we;
   logic [SEL_W-1:0]  wb_sel;
   logic [ADDR_W-1:0] wb_adr;
   logic [DATA_W-1:0] wb_dat_mosi;
   logic [DATA_W-1:0] wb_dat_miso;
   logic              wb_ack;
   logic              wb_err;

   modport master (
      input  req_valid, req_we, req_sel, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  rsp_ready,
      output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_mosi,
      input  wb_dat_miso, wb_ack, wb_err
   );

   modport slave (
      output req_valid, req_we, req_sel, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output rsp_ready,
      input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_mosi,
      output wb_dat_miso, wb_ack, wb_err
   );
endinterface

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: turns one CPU valid/ready request into a single
// Wishbone classic cycle, waits for ack/err (or a timeout) and returns the
// result through a valid/ready response. One transaction in flight.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   bus        - wb_master_bridge_if.master (req_*, rsp_*, wb_*)
//   stat_xfer  - completed-response count (32 bit, wraps)
//   stat_err   - errored-response count (16 bit, saturates)
//   dbg_state  - current FSM state (state_t encoding)
//
// Build option: define WB_MASTER_STATS_EN to build the stat counters;
// otherwise stat_xfer/stat_err are constant 0.
module wb_master_bridge #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int RDATA_DELAY    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wb_master_bridge_if.master   bus,
   output logic [31:0]          stat_xfer,
   output logic [15:0]          stat_err,
   output logic [1:0]           dbg_state
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUS, LAG, RESP} state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt;
   logic              accept, cap_rdata, set_err, set_to, rsp_fire;

   // Cycle/strobe, ready and valid are pure decodes of the state register,
   // so an asynchronous reset drops wb_cyc without waiting for an edge.
   assign bus.wb_cyc    = (state == BUS);
   assign bus.wb_stb    = (state == BUS);
   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign dbg_state     = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d   = state;
      accept    = 1'b0;
      cap_rdata = 1'b0;
      set_err   = 1'b0;
      set_to    = 1'b0;
      rsp_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept  = 1'b1;
               state_d = BUS;
            end
         end
         BUS: begin
            // err beats ack beats timeout
            if (bus.wb_err) begin
               set_err = 1'b1;
               state_d = RESP;
            end else if (bus.wb_ack) begin
               if (bus.wb_we || RDATA_DELAY == 0) begin
                  cap_rdata = !bus.wb_we;
                  state_d   = RESP;
               end else begin
                  state_d   = LAG;
               end
            end else if (cnt == CNT_LAST) begin
               set_err = 1'b1;
               set_to  = 1'b1;
               state_d = RESP;
            end
         end
         LAG: begin
            // slave's read data lands one cycle after its ack
            cap_rdata = 1'b1;
            state_d   = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_fire = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wb_we       <= 1'b0;
         bus.wb_sel      <= '0;
         bus.wb_adr      <= '0;
         bus.wb_dat_mosi <= '0;
         bus.rsp_rdata   <= '0;
         bus.rsp_err     <= 1'b0;
         bus.rsp_timeout <= 1'b0;
         cnt             <= '0;
      end else begin
         if (accept) begin
            bus.wb_we       <= bus.req_we;
            bus.wb_sel      <= bus.req_sel;
            bus.wb_adr      <= bus.req_addr;
            bus.wb_dat_mosi <= bus.req_wdata;
            // cleared here so writes and errors report zero read data
            bus.rsp_rdata   <= '0;
            cnt             <= '0;
         end else if (state == BUS) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (cap_rdata) bus.rsp_rdata <= bus.wb_dat_miso;
         if (set_err)   bus.rsp_err     <= 1'b1;
         if (set_to)    bus.rsp_timeout <= 1'b1;
         if (rsp_fire) begin
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
         end
      end
   end

`ifdef WB_MASTER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_xfer <= '0;
         stat_err  <= '0;
      end else if (rsp_fire) begin
         stat_xfer <= stat_xfer + 32'd1;
         if (bus.rsp_err && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end
   end
`else
   assign stat_xfer = '0;
   assign stat_err  = '0;
`endif

endmodule

// File: tb/tb_wb_master_bridge.sv
module tb_wb_master_bridge;
   localparam int TO = 16;

   logic        clk;
   logic        rst_n;
   logic [31:0] stat_xfer;
   logic [15:0] stat_err;
   logic [1:0]  dbg_state;

   wb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .RDATA_DELAY(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .stat_xfer (stat_xfer),
      .stat_err  (stat_err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- slave model ----------------
   // mode: 0 ack, 1 err, 2 ack+err together, 3 never answers
   int unsigned sl_mode;
   int unsigned sl_wait;
   logic [31:0] sl_rdata;
   int unsigned cyc_cnt;
   logic        ack_d;

   assign bus.wb_ack = bus.wb_cyc && (cyc_cnt == sl_wait) && (sl_mode == 0 || sl_mode == 2);
   assign bus.wb_err = bus.wb_cyc && (cyc_cnt == sl_wait) && (sl_mode == 1 || sl_mode == 2);
   assign bus.wb_dat_miso = ack_d ? sl_rdata : 32'h0BAD_F00D;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt <= 0;
         ack_d   <= 1'b0;
      end else begin
         cyc_cnt <= bus.wb_cyc ? cyc_cnt + 1 : 0;
         ack_d   <= bus.wb_ack;
      end
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   int n_xfer = 0;
   int n_err  = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      int unsigned mode;
      int unsigned wt;
      logic [31:0] rdata;
      int unsigned hold;
      logic        e_err;
      logic        e_to;
      logic [31:0] e_rdata;
      int unsigned e_lat;
      int unsigned e_cyc;
   } vec_t;

   // Reference: outcome of one transaction from the protocol rules alone.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      logic answers = (v.mode != 3) && (v.wt < TO);
      if (!answers) begin
         r.e_err = 1; r.e_to = 1; r.e_rdata = 0; r.e_cyc = TO; r.e_lat = TO + 1;
      end else if (v.mode != 0) begin
         r.e_err = 1; r.e_to = 0; r.e_rdata = 0; r.e_cyc = v.wt + 1; r.e_lat = v.wt + 2;
      end else begin
         r.e_err = 0; r.e_to = 0;
         r.e_rdata = v.we ? 32'h0 : v.rdata;
         r.e_cyc = v.wt + 1;
         r.e_lat = v.wt + 2 + (v.we ? 0 : 1);
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                               input logic [31:0] wdata, input int unsigned mode,
                               input int unsigned wt, input logic [31:0] rdata,
                               input int unsigned hold);
      vec_t v;
      v.we = we; v.sel = sel; v.addr = addr; v.wdata = wdata; v.mode = mode;
      v.wt = wt; v.rdata = rdata; v.hold = hold;
      v.e_err = 0; v.e_to = 0; v.e_rdata = 0; v.e_lat = 0; v.e_cyc = 0;
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic do_xact(input vec_t v, input string tag);
      int unsigned lat = 0;
      int unsigned cycs = 0;
      logic got = 1'b0;
      logic [31:0] r_rdata;
      logic r_err, r_to;
      logic [31:0] exp_rd;
      sl_mode = v.mode; sl_wait = v.wt; sl_rdata = v.rdata;
      exp_q.push_back(v.e_rdata);
      @(negedge clk);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_sel = v.sel;
      bus.req_addr = v.addr; bus.req_wdata = v.wdata;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      bus.req_wdata = $urandom; bus.req_addr = $urandom;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.wb_cyc) begin
            cycs++;
            if (cycs == 1) begin
               chk({tag, "_wb_adr"}, 64'(bus.wb_adr), 64'(v.addr));
               chk({tag, "_wb_we_sel"}, 64'({bus.wb_we, bus.wb_sel, bus.wb_stb}), 64'({v.we, v.sel, 1'b1}));
               if (v.we) chk({tag, "_wb_mosi"}, 64'(bus.wb_dat_mosi), 64'(v.wdata));
            end
         end
         if (bus.rsp_valid) begin
            lat = k; got = 1'b1;
            chk({tag, "_cyc_in_resp"}, 64'(bus.wb_cyc), 64'd0);
            break;
         end
      end
      exp_rd = exp_q.pop_front();
      if (!got) begin
         chk({tag, "_rsp_wait_expired"}, 64'd0, 64'd1);
         return;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(v.e_lat));
      chk({tag, "_cyc_cycles"}, 64'(cycs), 64'(v.e_cyc));
      chk({tag, "_rsp"}, {31'd0, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
          {31'd0, v.e_err, v.e_to, exp_rd});
      r_rdata = bus.rsp_rdata; r_err = bus.rsp_err; r_to = bus.rsp_timeout;
      for (int h = 0; h < int'(v.hold); h++) begin
         @(negedge clk);
         chk({tag, "_hold"}, {29'd0, bus.rsp_valid, bus.req_ready, r_err == bus.rsp_err,
                              r_to == bus.rsp_timeout, bus.rsp_rdata},
             {29'd0, 1'b1, 1'b0, 1'b1, 1'b1, r_rdata});
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      n_xfer++;
      if (v.e_err) n_err++;
      @(negedge clk);
      chk({tag, "_after_hs"}, 64'({bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_timeout}),
          64'(4'b0100));
   endtask

   task automatic chk_stats(input string tag);
`ifdef WB_MASTER_STATS_EN
      chk({tag, "_stat_xfer"}, 64'(stat_xfer), 64'(n_xfer));
      chk({tag, "_stat_err"}, 64'(stat_err), 64'(n_err));
`else
      chk({tag, "_stat_xfer"}, 64'(stat_xfer), 64'd0);
      chk({tag, "_stat_err"}, 64'(stat_err), 64'd0);
`endif
   endtask

   // ---------------- test ----------------
   vec_t tbl[$];
   vec_t v;

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 0; bus.req_we = 0; bus.req_sel = 0; bus.req_addr = 0;
      bus.req_wdata = 0; bus.rsp_ready = 0;
      sl_mode = 3; sl_wait = 0; sl_rdata = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {bus.wb_cyc, bus.wb_stb, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
                            bus.req_ready, bus.rsp_rdata},
          {6'b000001, 32'd0});
      chk("reset_stats", {stat_xfer, 16'd0, stat_err}, 64'd0);
      rst_n = 1'b1;

      // Hand-computed vectors for the named corner cases.
      v = mk(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0);
      v.e_err = 0; v.e_to = 0; v.e_rdata = 0; v.e_lat = 2; v.e_cyc = 1; tbl.push_back(v);
      v = mk(0, 4'hF, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF, 0);
      v.e_err = 0; v.e_to = 0; v.e_rdata = 32'hDEADBEEF; v.e_lat = 3; v.e_cyc = 1; tbl.push_back(v);
      v = mk(0, 4'h3, 32'h20, 32'h0, 3, 0, 32'h1234, 0);
      v.e_err = 1; v.e_to = 1; v.e_rdata = 0; v.e_lat = 17; v.e_cyc = 16; tbl.push_back(v);
      v = mk(0, 4'hF, 32'h30, 32'h0, 2, 0, 32'h5555AAAA, 5);
      v.e_err = 1; v.e_to = 0; v.e_rdata = 0; v.e_lat = 2; v.e_cyc = 1; tbl.push_back(v);
      v = mk(0, 4'h1, 32'h40, 32'h0, 1, 3, 32'h77, 0);
      v.e_err = 1; v.e_to = 0; v.e_rdata = 0; v.e_lat = 5; v.e_cyc = 4; tbl.push_back(v);
      v = mk(0, 4'hC, 32'h50, 32'h0, 0, 15, 32'hCAFEF00D, 1);
      v.e_err = 0; v.e_to = 0; v.e_rdata = 32'hCAFEF00D; v.e_lat = 18; v.e_cyc = 16; tbl.push_back(v);
      v = mk(1, 4'h8, 32'h60, 32'h01020304, 1, 15, 32'h0, 0);
      v.e_err = 1; v.e_to = 0; v.e_rdata = 0; v.e_lat = 17; v.e_cyc = 16; tbl.push_back(v);
      v = mk(1, 4'h6, 32'h70, 32'hA5A5A5A5, 0, 4, 32'h0, 2);
      v.e_err = 0; v.e_to = 0; v.e_rdata = 0; v.e_lat = 6; v.e_cyc = 5; tbl.push_back(v);

      for (int i = 0; i < tbl.size(); i++) do_xact(tbl[i], $sformatf("vec%0d", i));
      chk_stats("after_vectors");

      // Reset in the middle of a bus cycle: cyc must drop without an edge.
      sl_mode = 3;
      @(negedge clk);
      bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h99; bus.req_sel = 4'hF;
      @(posedge clk);
      #1 bus.req_valid = 0;
      repeat (3) @(negedge clk);
      chk("midrst_cyc_before", 64'(bus.wb_cyc), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_async", 64'({bus.wb_cyc, bus.wb_stb, bus.rsp_valid}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_xfer = 0; n_err = 0;
      chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
      chk_stats("midrst");
      v = model(mk(0, 4'hF, 32'h10, 32'h0, 0, 0, 32'h13579BDF, 0));
      do_xact(v, "post_rst_read");

      // Two more good ones plus a timeout: 3 good + 1 timeout since reset.
      do_xact(model(mk(1, 4'hF, 32'h14, 32'h11112222, 0, 1, 32'h0, 0)), "stat_w");
      do_xact(model(mk(0, 4'hF, 32'h18, 32'h0, 0, 2, 32'h33334444, 0)), "stat_r");
      do_xact(model(mk(1, 4'hF, 32'h1C, 32'h55556666, 3, 0, 32'h0, 0)), "stat_to");
      chk_stats("stats_3good_1to");

      // Randomized transactions against the reference model.
      for (int i = 0; i < 40; i++) begin
         int unsigned m = $urandom_range(0, 9);
         v = mk(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                (m < 6) ? 0 : (m < 8) ? 1 : (m < 9) ? 2 : 3,
                $urandom_range(0, 17), $urandom, $urandom_range(0, 3));
         do_xact(model(v), $sformatf("rnd%0d", i));
      end
      chk_stats("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #400000;
      $display("FAIL global_time_limit: got expired expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
